ram_xfer_ctrl: RTL and testbench

- Initiator-side master for the team's 64x32 single-port synchronous RAM.
  - Drives the RAM's cen/wen/addr/din.
  - Samples the RAM's registered dout one cycle after a read.
- Accepts one command at a time from the datapath/top FSM via a start/busy/done handshake.
- Commands: single read, single write, block fill, block copy.

---
 rtl/ram_xfer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ram_xfer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_xfer_ctrl.sv
// ram_xfer_ctrl: initiator-side master for a single-port synchronous RAM with
// registered read data. Executes one command at a time: single read, single
// write, block fill or forward block copy, handshaked through start/busy/done.
// Optional build macro RAMXFER_CHECKSUM_EN adds a running checksum output (csum)
// of every word written and every word captured by a single read.
module ram_xfer_ctrl #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              m_cen,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
`ifdef RAMXFER_CHECKSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    input  logic [DATA_W-1:0] m_dout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_COPY  = 2'b11;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W:0]   idx_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W:0] len_sat;
    logic [ADDR_W:0] idx_nxt;
    logic            accept;

    assign len_sat = (len > MAX_LEN) ? MAX_LEN : len;
    assign idx_nxt = idx_q + ONE;
    assign accept  = (state_q == S_IDLE) && start;

    // Next-state decode; zero-length fill/copy goes straight to DONE without touching RAM
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_READ:  state_d = S_RD;
                        OP_WRITE: state_d = S_WR;
                        OP_FILL:  state_d = (len_sat == '0) ? S_DONE : S_WR;
                        OP_COPY:  state_d = (len_sat == '0) ? S_DONE : S_RD;
                    endcase
                end
            end
            S_RD:   state_d = (op_q == OP_READ) ? S_CAP : S_WR;
            S_CAP:  state_d = S_DONE;
            S_WR: begin
                unique case (op_q)
                    OP_FILL:  state_d = (idx_nxt < len_q) ? S_WR : S_DONE;
                    OP_COPY:  state_d = (idx_nxt < len_q) ? S_RD : S_DONE;
                    default:  state_d = S_DONE;
                endcase
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, latched command and word index; command is captured only on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op;
                src_q   <= src_addr;
                dst_q   <= dst_addr;
                len_q   <= len_sat;
                wdata_q <= wdata;
                idx_q   <= '0;
            end else if (state_q == S_WR) begin
                idx_q <= idx_nxt;
            end
        end
    end

    // Single-read result, held until the next read captures
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (state_q == S_CAP) begin
            rdata_q <= m_dout;
        end
    end

    // Moore RAM strobes; copy writes pass the RAM's read data straight through
    always_comb begin
        m_cen  = 1'b0;
        m_wen  = 1'b0;
        m_addr = '0;
        m_din  = '0;
        if (state_q == S_RD) begin
            m_cen  = 1'b1;
            m_addr = src_q + idx_q[ADDR_W-1:0];
        end else if (state_q == S_WR) begin
            m_cen  = 1'b1;
            m_wen  = 1'b1;
            m_addr = dst_q + idx_q[ADDR_W-1:0];
            m_din  = (op_q == OP_COPY) ? m_dout : wdata_q;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign rdata = rdata_q;

`ifdef RAMXFER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    // Modular sum of words written and words captured, restarted per command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else if (accept) begin
            csum_q <= '0;
        end else if (state_q == S_WR) begin
            csum_q <= csum_q + m_din;
        end else if (state_q == S_CAP) begin
            csum_q <= csum_q + m_dout;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: tb/tb_ram_xfer_ctrl.sv
// Self-checking bench for ram_xfer_ctrl: a behavioural 64x32 RAM, a command-level
// reference model of memory contents, latency and access sequence, and directed
// plus randomized commands. Honours RAMXFER_CHECKSUM_EN when defined.
module tb_ram_xfer_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [5:0]  src_addr, dst_addr;
    logic [6:0]  len;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] rdata;
    logic        m_cen, m_wen;
    logic [5:0]  m_addr;
    logic [31:0] m_din;
    logic [31:0] m_dout;
`ifdef RAMXFER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    ram_xfer_ctrl #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .rdata    (rdata),
        .m_cen    (m_cen),
        .m_wen    (m_wen),
        .m_addr   (m_addr),
        .m_din    (m_din),
`ifdef RAMXFER_CHECKSUM_EN
        .csum     (csum),
`endif
        .m_dout   (m_dout)
    );

    always #5 clk = ~clk;

    // Behavioural RAM with registered read data and a preload port for setup
    logic [31:0] mem [64];
    logic        preload;
    logic [5:0]  pl_addr;
    logic [31:0] pl_data;

    always @(posedge clk) begin
        if (preload) begin
            mem[pl_addr] <= pl_data;
        end else if (m_cen) begin
            if (m_wen) mem[m_addr] <= m_din;
            else       m_dout <= mem[m_addr];
        end
    end

    // Reference state
    logic [31:0] exp_mem [64];
    logic [31:0] exp_rdata;
    logic [31:0] exp_csum;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cur_op = -1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s (op %0d): got %0h, expected %0h", tag, cur_op, got, exp);
        end
    endtask

    task automatic scramble();
        op       = 2'($urandom);
        src_addr = 6'($urandom);
        dst_addr = 6'($urandom);
        len      = 7'($urandom);
        wdata    = $urandom;
    endtask

    // Issue one command; poke raises a stray start while busy and in the done cycle
    task automatic do_cmd(input logic [1:0] o, input int s, input int d, input int l,
                          input logic [31:0] w, input bit poke);
        int          ne, lat_exp, acc_exp, lat, acc, a;
        bit          seen_done;
        logic        busy1;
        logic [31:0] v;
        logic [5:0]  ea[$];
        logic [31:0] ed[$];
        logic [5:0]  ga[$];
        logic [31:0] gd[$];
        cur_op   = int'(o);
        ne       = (l > 64) ? 64 : l;
        exp_csum = 32'h0;
        lat_exp  = 1;
        acc_exp  = 0;
        case (o)
            2'd0: begin
                lat_exp   = 3;
                acc_exp   = 1;
                exp_rdata = exp_mem[s % 64];
                exp_csum  = exp_rdata;
            end
            2'd1: begin
                lat_exp = 2;
                acc_exp = 1;
                ea.push_back(6'(d % 64));
                ed.push_back(w);
                exp_mem[d % 64] = w;
                exp_csum = w;
            end
            2'd2: begin
                lat_exp = (ne == 0) ? 1 : ne + 1;
                acc_exp = ne;
                for (int j = 0; j < ne; j++) begin
                    a = (d + j) % 64;
                    exp_mem[a] = w;
                    ea.push_back(6'(a));
                    ed.push_back(w);
                    exp_csum += w;
                end
            end
            default: begin
                lat_exp = (ne == 0) ? 1 : 2 * ne + 1;
                acc_exp = 2 * ne;
                for (int j = 0; j < ne; j++) begin
                    v = exp_mem[(s + j) % 64];
                    a = (d + j) % 64;
                    exp_mem[a] = v;
                    ea.push_back(6'(a));
                    ed.push_back(v);
                    exp_csum += v;
                end
            end
        endcase

        @(negedge clk);
        op = o; src_addr = 6'(s); dst_addr = 6'(d); len = 7'(l); wdata = w; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        lat = 0; acc = 0; seen_done = 1'b0; busy1 = 1'b0;
        for (int n = 1; n <= 300 && !seen_done; n++) begin
            @(negedge clk);
            if (n == 1) busy1 = busy;
            if (m_cen) begin
                acc++;
                if (m_wen) begin
                    ga.push_back(m_addr);
                    gd.push_back(m_din);
                end
            end
            if (done) begin
                seen_done = 1'b1;
                lat = n;
            end
            if (poke && (n == 1 || done)) begin
                scramble();
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        @(negedge clk);
        chk("idle_after_done", {busy, done, m_cen}, 3'b000);
        chk("done_latency", lat, lat_exp);
        chk("busy_first_cycle", busy1, 1'b1);
        chk("access_count", acc, acc_exp);
        chk("write_count", ga.size(), ea.size());
        for (int j = 0; j < ea.size() && j < ga.size(); j++) begin
            chk("write_addr", ga[j], ea[j]);
            chk("write_data", gd[j], ed[j]);
        end
        chk("rdata", rdata, exp_rdata);
`ifdef RAMXFER_CHECKSUM_EN
        chk("csum", csum, exp_csum);
`endif
    endtask

    initial begin
        int s, d, l;
        logic [31:0] w;
        reset_n = 1'b0;
        start   = 1'b0;
        preload = 1'b1;
        scramble();
        exp_rdata = 32'h0;
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_cen_wen", {m_cen, m_wen}, 2'b00);
        chk("reset_addr", m_addr, 6'h0);
        chk("reset_din", m_din, 32'h0);
`ifdef RAMXFER_CHECKSUM_EN
        chk("reset_csum", csum, 32'h0);
`endif
        for (int i = 0; i < 64; i++) begin
            pl_addr = 6'(i);
            pl_data = $urandom;
            exp_mem[i] = pl_data;
            @(posedge clk);
            #1;
        end
        preload = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Single write then read back
        do_cmd(2'd1, 0, 5, 0, 32'hDEADBEEF, 1'b0);
        do_cmd(2'd0, 5, 0, 0, 32'h0, 1'b0);
        chk("read_deadbeef", rdata, 32'hDEADBEEF);

        // Fill wrapping past the top of memory
        do_cmd(2'd2, 0, 62, 4, 32'h12345678, 1'b0);
        for (int i = 0; i < 5; i++) do_cmd(2'd0, (62 + i) % 64, 0, 0, 32'h0, 1'b0);

        // Copy of a small block
        do_cmd(2'd1, 0, 0, 0, 32'h1, 1'b0);
        do_cmd(2'd1, 0, 1, 0, 32'h2, 1'b0);
        do_cmd(2'd1, 0, 2, 0, 32'h3, 1'b0);
        do_cmd(2'd3, 0, 32, 3, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) do_cmd(2'd0, 32 + i, 0, 0, 32'h0, 1'b0);

        // Zero-length fill and copy, with stray starts
        do_cmd(2'd2, 0, 7, 0, 32'hFFFF0000, 1'b1);
        do_cmd(2'd3, 3, 9, 0, 32'h0, 1'b1);

        // Overlapping forward copy propagates the first word
        do_cmd(2'd1, 0, 0, 0, 32'hA, 1'b0);
        do_cmd(2'd3, 0, 1, 3, 32'h0, 1'b0);
        for (int i = 1; i < 4; i++) do_cmd(2'd0, i, 0, 0, 32'h0, 1'b0);

        // Saturating length and checksum wrap
        do_cmd(2'd2, 0, 40, 100, 32'h0BADF00D, 1'b1);
        do_cmd(2'd2, 0, 20, 4, 32'h40000000, 1'b0);
        do_cmd(2'd3, 20, 50, 64, 32'h0, 1'b0);

        // Reset during the second write of a fill: only the first word lands
        cur_op = 2;
        w = $urandom;
        exp_mem[10] = w;
        @(negedge clk);
        op = 2'd2; src_addr = 6'd0; dst_addr = 6'd10; len = 7'd8; wdata = w; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("second_wr_active", {m_cen, m_wen, m_addr}, {2'b11, 6'd11});
        reset_n = 1'b0;
        #1;
        chk("async_reset_strobes", {m_cen, m_wen, busy, done}, 4'b0000);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_rdata = 32'h0;
        chk("rdata_after_reset", rdata, 32'h0);
        do_cmd(2'd0, 10, 0, 0, 32'h0, 1'b0);
        do_cmd(2'd0, 11, 0, 0, 32'h0, 1'b0);

        // Randomized commands
        for (int k = 0; k < 40; k++) begin
            s = $urandom_range(0, 63);
            d = $urandom_range(0, 63);
            l = $urandom_range(0, 12);
            if ($urandom_range(0, 9) == 0) l = $urandom_range(65, 127);
            do_cmd(2'($urandom_range(0, 3)), s, d, l, $urandom, 1'($urandom_range(0, 1)));
        end

        // Final memory image
        cur_op = -1;
        for (int i = 0; i < 64; i++) chk("mem_image", mem[i], exp_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
